// File: rtl/fft_pipe_seq_if.sv
// Handshake and status bundle between the FFT sequencer and its controller.
// The master side drives the commands and output backpressure; the slave
// side (the sequencer) drives the step/enable/address and result signals.
interface fft_pipe_seq_if #(
    parameter int NSTAGES = 3,
    parameter int ROW_W   = 32
);
    logic               start;
    logic               mode;
    logic               stop;
    logic               out_ready;
    logic               step;
    logic [ROW_W-1:0]   row_sel;
    logic [NSTAGES-1:0] stage_en;
    logic               out_valid;
    logic [ROW_W-1:0]   out_row;
    logic               busy;
    logic               done;

    modport master (
        output start, mode, stop, out_ready,
        input  step, row_sel, stage_en, out_valid, out_row, busy, done
    );

    modport slave (
        input  start, mode, stop, out_ready,
        output step, row_sel, stage_en, out_valid, out_row, busy, done
    );
endinterface

// File: rtl/fft_pipe_seq.sv
// Sequencer for the multi-stage FFT datapath. A cycle counter paces one
// step every CT cycles; each step shifts a valid/tag pipeline that mirrors
// the datapath stages, issues the next input row while running, and
// presents the result at the last stage through a ready/valid handshake.
// A stalled output freezes the counter at its terminal value so the step
// fires in the same cycle the consumer becomes ready.
module fft_pipe_seq #(
    parameter int CT      = 40,
    parameter int NSTAGES = 3,
    parameter int NROWS   = 64,
    parameter int ROW_W   = 32
) (
    input  logic          clk,
    input  logic          reset,
    fft_pipe_seq_if.slave bus
);

    localparam int                CNT_W   = (CT > 1) ? $clog2(CT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CT - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(NROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [ROW_W-1:0]   row_q,      row_d;
    logic [NSTAGES-1:0] vld_q,      vld_d;
    logic [ROW_W-1:0]   tag_q [NSTAGES];
    logic [ROW_W-1:0]   tag_d [NSTAGES];
    logic               taken_q,    taken_d;
    logic               stop_req_q, stop_req_d;

    logic               active;
    logic               out_valid;
    logic               stall;
    logic               step;
    logic               issue;
    logic               xfer;
    logic               drain_done;
    logic [NSTAGES-1:0] stage_en;

    // Handshake and pacing terms derived from the current register state.
    always_comb begin
        active     = (state_q != S_IDLE);
        out_valid  = vld_q[NSTAGES-1] & ~taken_q;
        stall      = out_valid & ~bus.out_ready;
        step       = active & (cnt_q == CNT_MAX) & ~stall;
        issue      = (state_q == S_RUN) & ~stop_req_q;
        xfer       = out_valid & bus.out_ready;
        drain_done = (state_q == S_DRAIN) & (vld_q == '0);
        stage_en   = '0;
        stage_en[0] = step & issue;
        for (int i = 1; i < NSTAGES; i++) begin
            stage_en[i] = step & vld_q[i-1];
        end
    end

    // Next-state logic: FSM transitions, step counter, row address,
    // valid/tag shift pipeline and output-consumed flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        vld_d      = vld_q;
        tag_d      = tag_q;
        taken_d    = taken_q;
        stop_req_d = stop_req_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    row_d      = '0;
                    stop_req_d = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    stop_req_d = 1'b1;
                end
                if (step) begin
                    // A pending stop turns this step into the first drain step;
                    // a single pass ends on the step that issues the last row.
                    if (stop_req_q) begin
                        state_d = S_DRAIN;
                    end else if ((row_q == ROW_MAX) && !bus.mode) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter wraps on a step and parks at its terminal count while stalled.
        if (active) begin
            if (step) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (drain_done) begin
            cnt_d = '0;
        end

        if (step && issue) begin
            if (row_q == ROW_MAX) begin
                if (bus.mode) begin
                    row_d = '0;
                end
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end

        if (step) begin
            vld_d[0] = issue;
            tag_d[0] = row_q;
            for (int i = 1; i < NSTAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end

        // A step presents a fresh result, so it wins over a same-cycle transfer.
        if (step) begin
            taken_d = 1'b0;
        end else if (xfer) begin
            taken_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            vld_q      <= '0;
            tag_q      <= '{default: '0};
            taken_q    <= 1'b0;
            stop_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            taken_q    <= taken_d;
            stop_req_q <= stop_req_d;
        end
    end

    assign bus.step      = step;
    assign bus.row_sel   = row_q;
    assign bus.stage_en  = stage_en;
    assign bus.out_valid = out_valid;
    assign bus.out_row   = tag_q[NSTAGES-1];
    assign bus.busy      = active;
    assign bus.done      = drain_done;

endmodule

// File: tb/tb_fft_pipe_seq.sv
// Self-checking bench for fft_pipe_seq: directed cycle-exact scenarios with
// expectations computed from the step/latency formulas, then randomized
// backpressure and stop runs checked against a row-order scoreboard.
module tb_fft_pipe_seq;

    localparam int CT_A = 4;
    localparam int NS_A = 3;
    localparam int NR_A = 4;

    logic clk = 1'b0;
    logic reset;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    fft_pipe_seq_if #(.NSTAGES(NS_A), .ROW_W(32)) ifa ();
    fft_pipe_seq_if #(.NSTAGES(NS_A), .ROW_W(32)) ifb ();

    fft_pipe_seq #(.CT(CT_A), .NSTAGES(NS_A), .NROWS(NR_A), .ROW_W(32)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ifa)
    );

    fft_pipe_seq #(.CT(1), .NSTAGES(NS_A), .NROWS(NR_A), .ROW_W(32)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single no-stall pass on instance A; an optional extra start pulse at
    // cycle 'restart' must have no effect.
    task automatic pass_single(input string tn, input int restart);
        int       k, r;
        bit       es, ev;
        logic [NS_A-1:0] ee;
        for (int c = 0; c < 32; c++) begin
            ifa.start     = (c == 0) || (c == restart);
            ifa.mode      = 1'b0;
            ifa.stop      = 1'b0;
            ifa.out_ready = 1'b1;
            @(negedge clk);
            k  = c / CT_A;
            es = (c % CT_A == 0) && (k >= 1) && (k <= NR_A + NS_A);
            ee = '0;
            if (es) begin
                for (int i = 0; i < NS_A; i++) begin
                    ee[i] = ((k - 1 - i) >= 0) && ((k - 1 - i) < NR_A);
                end
            end
            r  = (c - 1) / CT_A - NS_A;
            ev = (c >= 1) && ((c - 1) % CT_A == 0) && (r >= 0) && (r < NR_A);
            chk($sformatf("%s step c%0d", tn, c), ifa.step, es);
            chk($sformatf("%s stage_en c%0d", tn, c), ifa.stage_en, ee);
            chk($sformatf("%s out_valid c%0d", tn, c), ifa.out_valid, ev);
            if (ev) chk($sformatf("%s out_row c%0d", tn, c), ifa.out_row, r);
            if (es && ee[0]) chk($sformatf("%s row_sel c%0d", tn, c), ifa.row_sel, k - 1);
            chk($sformatf("%s done c%0d", tn, c), ifa.done, c == (NR_A + NS_A) * CT_A + 1);
            chk($sformatf("%s busy c%0d", tn, c), ifa.busy, (c >= 1) && (c <= (NR_A + NS_A) * CT_A + 1));
            next_cycle();
        end
        ifa.start = 1'b0;
    endtask

    initial begin
        int  k, r, m, stop_at, exp_row, n_iss, iss_after_stop, n_xfer;
        bit  es, ev, seen_done, prev_stall;
        logic [31:0] prev_row;
        int  q[$];

        reset         = 1'b0;
        ifa.start     = 1'b0; ifa.mode = 1'b0; ifa.stop = 1'b0; ifa.out_ready = 1'b1;
        ifb.start     = 1'b0; ifb.mode = 1'b0; ifb.stop = 1'b0; ifb.out_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst step",      ifa.step,      0);
        chk("rst row_sel",   ifa.row_sel,   0);
        chk("rst stage_en",  ifa.stage_en,  0);
        chk("rst out_valid", ifa.out_valid, 0);
        chk("rst out_row",   ifa.out_row,   0);
        chk("rst busy",      ifa.busy,      0);
        chk("rst done",      ifa.done,      0);
        chk("rst b busy",    ifb.busy,      0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Basic single pass, including the stage_en fill/drain pattern.
        pass_single("t1", -1);

        // Output stall on row 1 during cycles 17..26.
        for (int c = 0; c < 40; c++) begin
            ifa.start     = (c == 0);
            ifa.mode      = 1'b0;
            ifa.stop      = 1'b0;
            ifa.out_ready = !((c >= 17) && (c <= 26));
            @(negedge clk);
            es = (c == 4) || (c == 8) || (c == 12) || (c == 16) ||
                 (c == 27) || (c == 31) || (c == 35);
            ev = (c == 13) || ((c >= 17) && (c <= 28)) || (c == 32);
            chk($sformatf("t3 step c%0d", c), ifa.step, es);
            chk($sformatf("t3 out_valid c%0d", c), ifa.out_valid, ev);
            if ((c >= 17) && (c <= 27)) chk($sformatf("t3 out_row c%0d", c), ifa.out_row, 1);
            if (c == 28) chk("t3 out_row c28", ifa.out_row, 2);
            if (c == 32) chk("t3 out_row c32", ifa.out_row, 3);
            if ((c >= 17) && (c <= 26)) chk($sformatf("t3 row_sel c%0d", c), ifa.row_sel, NR_A - 1);
            chk($sformatf("t3 done c%0d", c), ifa.done, c == 36);
            chk($sformatf("t3 busy c%0d", c), ifa.busy, (c >= 1) && (c <= 36));
            next_cycle();
        end

        // Continuous mode with wrap, stop after the 6th step.
        for (int c = 0; c < 40; c++) begin
            ifa.start     = (c == 0);
            ifa.mode      = 1'b1;
            ifa.stop      = (c == 25);
            ifa.out_ready = 1'b1;
            @(negedge clk);
            k  = c / CT_A;
            es = (c % CT_A == 0) && (k >= 1) && (k <= 9);
            r  = (c - 1) / CT_A - NS_A;
            ev = (c >= 1) && ((c - 1) % CT_A == 0) && (r >= 0) && (r < 6);
            chk($sformatf("t4 step c%0d", c), ifa.step, es);
            chk($sformatf("t4 issue c%0d", c), ifa.stage_en[0], es && (k <= 6));
            if (es && (k <= 6)) chk($sformatf("t4 row_sel c%0d", c), ifa.row_sel, (k - 1) % NR_A);
            chk($sformatf("t4 out_valid c%0d", c), ifa.out_valid, ev);
            if (ev) chk($sformatf("t4 out_row c%0d", c), ifa.out_row, r % NR_A);
            chk($sformatf("t4 done c%0d", c), ifa.done, c == 37);
            chk($sformatf("t4 busy c%0d", c), ifa.busy, (c >= 1) && (c <= 37));
            next_cycle();
        end
        ifa.mode = 1'b0;

        // Reset asserted mid-run while all stages hold valid rows.
        for (int c = 0; c < 16; c++) begin
            ifa.start     = (c == 0);
            ifa.out_ready = 1'b1;
            reset         = !(c == 14);
            @(negedge clk);
            if (c == 14) chk("t5 busy before reset", ifa.busy, 1);
            if (c == 15) begin
                chk("t5 step",      ifa.step,      0);
                chk("t5 row_sel",   ifa.row_sel,   0);
                chk("t5 stage_en",  ifa.stage_en,  0);
                chk("t5 out_valid", ifa.out_valid, 0);
                chk("t5 out_row",   ifa.out_row,   0);
                chk("t5 busy",      ifa.busy,      0);
                chk("t5 done",      ifa.done,      0);
            end
            next_cycle();
        end
        reset = 1'b1;
        pass_single("t5b", -1);

        // Start re-pulsed while running is ignored.
        pass_single("t6", 6);

        // CT=1 instance: step every cycle, row 0 valid in cycle 4.
        for (int c = 0; c < 10; c++) begin
            ifb.start = (c == 0);
            @(negedge clk);
            if (c <= 7) chk($sformatf("t6b step c%0d", c), ifb.step, c >= 1);
            ev = (c >= 4) && (c <= 7);
            chk($sformatf("t6b out_valid c%0d", c), ifb.out_valid, ev);
            if (ev) chk($sformatf("t6b out_row c%0d", c), ifb.out_row, c - 4);
            chk($sformatf("t6b done c%0d", c), ifb.done, c == 8);
            chk($sformatf("t6b busy c%0d", c), ifb.busy, (c >= 1) && (c <= 8));
            next_cycle();
        end
        ifb.start = 1'b0;

        // Randomized backpressure and stop timing against a row scoreboard.
        for (int it = 0; it < 6; it++) begin
            m              = (it < 2) ? 0 : ((it < 4) ? 1 : int'($urandom_range(0, 1)));
            stop_at        = $urandom_range(10, 90);
            exp_row        = 0;
            n_iss          = 0;
            n_xfer         = 0;
            iss_after_stop = 0;
            seen_done      = 1'b0;
            prev_stall     = 1'b0;
            prev_row       = '0;
            q.delete();
            for (int c = 0; c < 1500 && !seen_done; c++) begin
                ifa.start     = (c == 0);
                ifa.mode      = m[0];
                ifa.stop      = (m == 1) && (c == stop_at);
                ifa.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (prev_stall) begin
                    chk($sformatf("rnd%0d hold valid c%0d", it, c), ifa.out_valid, 1);
                    chk($sformatf("rnd%0d hold row c%0d", it, c), ifa.out_row, prev_row);
                end
                if (ifa.stage_en[0]) begin
                    chk($sformatf("rnd%0d row_sel c%0d", it, c), ifa.row_sel, exp_row);
                    q.push_back(exp_row);
                    exp_row = (exp_row + 1) % NR_A;
                    n_iss++;
                    if ((m == 1) && (c > stop_at)) iss_after_stop++;
                end
                if (ifa.out_valid && ifa.out_ready) begin
                    chk($sformatf("rnd%0d xfer expected c%0d", it, c), q.size() > 0, 1);
                    if (q.size() > 0) chk($sformatf("rnd%0d out_row c%0d", it, c), ifa.out_row, q.pop_front());
                    n_xfer++;
                end
                if (ifa.out_valid && !ifa.out_ready) begin
                    chk($sformatf("rnd%0d stall step c%0d", it, c), ifa.step, 0);
                end
                if (ifa.done) begin
                    seen_done = 1'b1;
                    chk($sformatf("rnd%0d drained at done", it), q.size(), 0);
                end
                prev_stall = ifa.out_valid && !ifa.out_ready;
                prev_row   = ifa.out_row;
                next_cycle();
            end
            ifa.start = 1'b0;
            ifa.stop  = 1'b0;
            chk($sformatf("rnd%0d done seen", it), seen_done, 1);
            chk($sformatf("rnd%0d xfers", it), n_xfer, n_iss);
            if (m == 0) chk($sformatf("rnd%0d issued", it), n_iss, NR_A);
            else        chk($sformatf("rnd%0d issue after stop", it), iss_after_stop, 0);
            @(negedge clk);
            chk($sformatf("rnd%0d idle after done", it), ifa.busy, 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_pipe_seq.md
Name: fft_pipe_seq

Overview:
- Parametrised sequencer for the multi-stage FFT datapath.
- Generates the per-step advance pulse, the input row address, per-stage pipe-register write enables and a tagged ready/valid output.
- Supersedes the fixed gate-plus-row-counter arrangement; adds single/continuous modes, stop/drain, per-stage enable gating and output backpressure.

Parameters:
CT, 40, cycles per pipeline step (>=1)
NSTAGES, 3, number of pipe stages tracked (>=1)
NROWS, 64, rows per pass (>=1)
ROW_W, 32, width of row_sel/out_row

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  begin pass; sampled only in IDLE
mode  in  1  0 = single pass, 1 = continuous (row_sel wraps)
stop  in  1  end continuous run; sampled in RUN
out_ready  in  1  downstream accepts output
step  out  1  one-cycle advance pulse
row_sel  out  ROW_W  input row address presented to memory
stage_en  out  NSTAGES  per-stage pipe-register write enable
out_valid  out  1  output stage holds unconsumed result
out_row  out  ROW_W  row index of result at output
busy  out  1  state != IDLE
done  out  1  one-cycle end-of-pass pulse

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, cnt=0, row_sel=0, vld=0, tags=0, taken=0, stop_req=0. All outputs 0 in the following cycle. Reset overrides everything, including mid-operation.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. Clears row_sel, cnt and stop_req.
  - start outside IDLE is ignored.
- cnt counts 0..CT-1 in RUN and DRAIN.
- step = (cnt==CT-1) & !stall, where stall = out_valid & !out_ready.
  - On step, cnt wraps to 0.
  - While stalled, cnt holds at CT-1, so step fires in the same cycle out_ready rises.
  - With start accepted in cycle 0, step k occurs in cycle k*CT when there is no stall.
- issue = (state==RUN) & !stop_req. A row is issued on a step where issue=1.
- vld[NSTAGES-1:0] and tag[i] shift on step:
  - vld[0] <= issue; tag[0] <= row_sel
  - vld[i] <= vld[i-1]; tag[i] <= tag[i-1]
- stage_en[0] = step & issue. stage_en[i] = step & vld[i-1].
- row_sel advances on each issuing step.
  - At NROWS-1 in single mode: row_sel holds and state -> DRAIN on that step.
  - At NROWS-1 in continuous mode: row_sel wraps to 0.
- stop asserted in RUN sets stop_req. The next step issues nothing, and state -> DRAIN.
- out_valid = vld[NSTAGES-1] & !taken. out_row = tag[NSTAGES-1].
  - Transfer occurs when out_valid & out_ready; this sets taken.
  - Any step clears taken; this has priority over a same-cycle transfer setting it.
  - A transfer and a step in the same cycle are legal.
- Latency: row r first shows out_valid in cycle (r+NSTAGES)*CT+1, assuming no stalls.
- DRAIN continues stepping, shifting 0 into vld.
  - In the cycle DRAIN sees vld==0: done=1, then state -> IDLE.
  - stop in DRAIN and start in DRAIN are ignored.
- CT=1: step fires every unstalled cycle.
- NSTAGES=1: vld[0] feeds the output directly.

Test Plan:
1. CT=4, NSTAGES=3, NROWS=4, mode=0, out_ready=1; start in cycle 0.
   - step in cycles 4, 8, ..., 28.
   - out_valid in cycles 13, 17, 21, 25 with out_row = 0, 1, 2, 3.
   - done=1 in cycle 29 only; busy low from cycle 30.
2. Same setup, stage_en sequence.
   - During fill: 001, 011, 111, 111.
   - During drain: 110, 100, 000.
3. Same setup, out_ready=0 in cycles 17..26 (row 1 pending).
   - out_valid and out_row=1 hold throughout; no step; row_sel holds.
   - step fires in cycle 27, when out_ready returns.
4. mode=1, NROWS=4.
   - row_sel sequence 0, 1, 2, 3, 0, 1.
   - stop pulse after the 6th step: the 7th step issues nothing; three drain steps follow; done after the last output.
5. reset=0 asserted mid-RUN with vld=111.
   - Next cycle: every output is 0 and state is IDLE.
   - start then behaves exactly as in test 1.
6. Same setup as test 1 (CT=4, NSTAGES=3, NROWS=4, mode=0, out_ready=1), but start re-pulsed in cycle 6 (RUN): ignored.
   - Separate run with CT=1: step every cycle; row 0 out_valid in cycle 4.
